cpu_mc_param: RTL

CPU_MC_PARAM -- requirements
Module: cpu_mc_param

---
 rtl/cpu_mc_param.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cpu_mc_param.sv
// Parameterised multi-cycle CPU with a shared instruction/data memory port.
// FETCH/DECODE/EXEC/MEM/WB sequencing; STOP is left only through reset.
module cpu_mc_param #(
  parameter int unsigned DATA_W   = 36,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned NREGS    = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] read_data,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  output logic              halted,
  output logic              illegal
);

  localparam int unsigned RA = $clog2(NREGS);

  if (DATA_W < 6 + 3 * RA + ADDR_W) begin : g_bad_width
    $error("DATA_W too narrow for op/rd/rs/rt/imm fields");
  end
  if ((1 << RA) != NREGS) begin : g_bad_nregs
    $error("NREGS must be a power of two");
  end

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_SLT  = 6'h04;
  localparam logic [5:0] OP_LW   = 6'h10;
  localparam logic [5:0] OP_SW   = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h12;
  localparam logic [5:0] OP_JMP  = 6'h13;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, STOP
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir, a, b;
  logic [DATA_W-1:0] alu_out, mdr;
  logic [DATA_W-1:0] alu_res, imm;
  logic [DATA_W-1:0] rf [NREGS];

  logic [5:0]    op;
  logic [RA-1:0] rd, rs, rt;

  logic is_rtype, is_lw, is_sw;
  logic is_beq, is_jmp, is_halt;
  logic unused_ok;

  assign op  = ir[DATA_W-1 -: 6];
  assign rd  = ir[DATA_W-7 -: RA];
  assign rs  = ir[DATA_W-7-RA -: RA];
  assign rt  = ir[DATA_W-7-2*RA -: RA];
  assign imm = DATA_W'(ir[ADDR_W-1:0]);

  assign unused_ok = ^ir;

  assign is_rtype = (op <= OP_SLT);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_jmp   = (op == OP_JMP);
  assign is_halt  = (op == OP_HALT);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = (a < b) ? DATA_W'(1) : '0;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH:  if (mem_ready) state_nx = DECODE;
      DECODE: state_nx = EXEC;
      EXEC: begin
        unique case (1'b1)
          is_rtype:     state_nx = WB;
          is_lw, is_sw: state_nx = MEM;
          is_beq:       state_nx = FETCH;
          is_jmp:       state_nx = FETCH;
          default:      state_nx = STOP;
        endcase
      end
      MEM: begin
        if (mem_ready) state_nx = is_lw ? WB : FETCH;
      end
      WB:      state_nx = FETCH;
      STOP:    state_nx = STOP;
      default: state_nx = FETCH;
    endcase
  end

  // Request is gated by reset so it drops without waiting for a clock.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    addr       = pc;
    write_data = b;
    unique case (state)
      FETCH: mem_req = reset;
      MEM: begin
        mem_req   = reset;
        mem_write = reset & is_sw;
        addr      = alu_out[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= ADDR_W'(RESET_PC);
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++)
        rf[i] <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (mem_ready) begin
            ir <= read_data;
            pc <= pc + 1'b1;
          end
        end
        DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
        end
        EXEC: begin
          unique case (1'b1)
            is_rtype:     alu_out <= alu_res;
            is_lw, is_sw: alu_out <= a + imm;
            is_beq: begin
              if (a == b) pc <= ir[ADDR_W-1:0];
            end
            is_jmp:  pc <= ir[ADDR_W-1:0];
            is_halt: halted <= 1'b1;
            default: illegal <= 1'b1;
          endcase
        end
        MEM: begin
          if (mem_ready && is_lw) mdr <= read_data;
        end
        WB: begin
          if (rd != '0) rf[rd] <= is_lw ? mdr : alu_out;
        end
        default: ;
      endcase
    end
  end

endmodule
